// File: rtl/fifo_collect.sv
// Serial-in, parallel-out collector: assembles DEPTH signed elements into a held vector.
// full is visible the cycle after the DEPTH-th accept; a new vector may start on the read edge. Writes while full are dropped and flagged in ovf.
module fifo_collect #(
   parameter int DEPTH = 8,
   parameter int BITS  = 8,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic signed [BITS-1:0] d,
   input  logic                   rd,
   output logic signed [BITS-1:0] q [DEPTH],
   output logic                   full,
   output logic [CW-1:0]          count,
   output logic                   ovf
);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic signed [BITS-1:0] q_q [DEPTH];
   logic signed [BITS-1:0] q_d [DEPTH];

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      q_d     = q_q;
      case (state_q)
         FILL: begin
            // The write index is count itself; slots above count are never touched.
            if (en) begin
               for (int k = 0; k < DEPTH; k++) begin
                  if (count_q == CW'(k)) q_d[k] = d;
               end
               count_d = count_q + CW'(1);
               if (count_q == CW'(DEPTH - 1)) state_d = FULL;
            end
         end
         FULL: begin
            if (rd) begin
               count_d = '0;
               state_d = FILL;
               if (en) begin
                  q_d[0]  = d;
                  count_d = CW'(1);
               end
            end else if (en) begin
               ovf_d = 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < DEPTH; k++) q_q[k] <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         q_q     <= q_d;
      end
   end

   assign q     = q_q;
   assign full  = (state_q == FULL);
   assign count = count_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_fifo_collect.sv
// Directed bench for fifo_collect (DEPTH=8, BITS=8) with immediate-assertion checks.
module tb_fifo_collect;

   localparam int DEPTH = 8;
   localparam int BITS  = 8;

   logic                   clk;
   logic                   rst_n;
   logic                   en;
   logic signed [BITS-1:0] d;
   logic                   rd;
   logic signed [BITS-1:0] q [DEPTH];
   logic                   full;
   logic [3:0]             count;
   logic                   ovf;

   int checks = 0;
   int errors = 0;

   fifo_collect #(.DEPTH(DEPTH), .BITS(BITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (d),
      .rd    (rd),
      .q     (q),
      .full  (full),
      .count (count),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input int exp [DEPTH]);
      for (int k = 0; k < DEPTH; k++)
         chk($sformatf("%s q[%0d]", tag, k), int'(q[k]), exp[k]);
   endtask

   initial begin
      int v1 [DEPTH] = '{1, -2, 3, -4, 5, -6, 7, -8};
      int v3 [DEPTH] = '{-128, 20, 21, 22, 23, 24, 25, 26};
      int v6 [DEPTH] = '{-128, 127, 0, -1, 64, -64, 1, -2};
      int zero [DEPTH] = '{0, 0, 0, 0, 0, 0, 0, 0};
      int pat [11] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
      int v4 [DEPTH];
      int acc;

      rst_n = 1'b0; en = 1'b0; rd = 1'b0; d = '0;
      #3;
      chk("reset count", int'(count), 0);
      chk("reset full", int'(full), 0);
      chk("reset ovf", int'(ovf), 0);
      chk_vec("reset", zero);
      #4 rst_n = 1'b1;

      // 1: plain fill
      for (int i = 0; i < DEPTH; i++) begin
         en = 1'b1; d = BITS'(v1[i]);
         tick();
         chk($sformatf("s1 count step %0d", i), int'(count), i + 1);
         chk($sformatf("s1 full step %0d", i), int'(full), (i == DEPTH - 1) ? 1 : 0);
      end
      en = 1'b0;
      chk_vec("s1", v1);
      chk("s1 ovf", int'(ovf), 0);

      // 2: overflow while full, then a lone read
      en = 1'b1; d = 8'sd99;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("s2 ovf %0d", i), int'(ovf), 1);
         chk($sformatf("s2 count %0d", i), int'(count), 8);
         chk($sformatf("s2 full %0d", i), int'(full), 1);
      end
      chk_vec("s2 hold", v1);
      en = 1'b0; rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("s2 rd full", int'(full), 0);
      chk("s2 rd count", int'(count), 0);
      chk("s2 rd ovf sticky", int'(ovf), 1);

      // 3: simultaneous read and write, zero-bubble restart
      rst_n = 1'b0;
      #2;
      chk("s3 reset ovf", int'(ovf), 0);
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         en = 1'b1; d = BITS'(10 + i);
         tick();
      end
      chk("s3 full after fill", int'(full), 1);
      rd = 1'b1; en = 1'b1; d = -8'sd128;
      tick();
      rd = 1'b0;
      chk("s3 rd+en full", int'(full), 0);
      chk("s3 rd+en count", int'(count), 1);
      chk("s3 rd+en q0", int'(q[0]), -128);
      chk("s3 rd+en ovf", int'(ovf), 0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         en = 1'b1; d = BITS'(20 + i);
         tick();
      end
      en = 1'b0;
      chk("s3 refill full", int'(full), 1);
      chk_vec("s3", v3);

      // 4: gapped input with rd held high during fill
      rd = 1'b1;
      tick();
      chk("s4 drain count", int'(count), 0);
      acc = 0;
      for (int i = 0; i < 11; i++) begin
         en = (pat[i] == 1);
         d = (pat[i] == 1) ? BITS'(40 + i) : 8'sd77;
         if (pat[i] == 1) begin
            v4[acc] = 40 + i;
            acc++;
         end
         tick();
         if (acc == DEPTH) rd = 1'b0;
         chk($sformatf("s4 count step %0d", i), int'(count), acc);
         chk($sformatf("s4 full step %0d", i), int'(full), (acc == DEPTH) ? 1 : 0);
      end
      en = 1'b0; rd = 1'b0;
      chk_vec("s4", v4);

      // 5: asynchronous reset mid-fill
      rd = 1'b1;
      tick();
      rd = 1'b0;
      for (int i = 0; i < 5; i++) begin
         en = 1'b1; d = BITS'(i + 1);
         tick();
      end
      en = 1'b0;
      chk("s5 count before reset", int'(count), 5);
      #3 rst_n = 1'b0;
      #1;
      chk("s5 async count", int'(count), 0);
      chk("s5 async full", int'(full), 0);
      chk("s5 async ovf", int'(ovf), 0);
      chk_vec("s5 async", zero);
      rst_n = 1'b1;

      // 6: extremes refill from index 0
      for (int i = 0; i < DEPTH; i++) begin
         en = 1'b1; d = BITS'(v6[i]);
         tick();
      end
      en = 1'b0;
      chk("s6 full", int'(full), 1);
      chk("s6 count", int'(count), 8);
      chk("s6 ovf", int'(ovf), 0);
      chk_vec("s6", v6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
